// File: rtl/axis_pkt_arbiter_pkg.sv
// Shared definitions for the packet-granular 2:1 AXI-Stream arbiter.
// The state and source encodings are plain constants so the existing netlists and scripts keep the same bit patterns.
package axis_pkt_arbiter_pkg;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_BUSY = 1'b1;

    localparam logic SRC0 = 1'b0;
    localparam logic SRC1 = 1'b1;

    function automatic logic [1:0] src_onehot(input logic src);
        return (src == SRC1) ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/axis_pkt_arbiter_if.sv
// AXI-Stream bundle (tvalid/tready/tdata/tlast/tuser).
// The master modport is the side that drives tvalid, and the slave modport is the side that drives tready.
interface axis_pkt_arbiter_if #(
    parameter int unsigned C_AXIS_TDATA_WIDTH = 32
);

    logic                          tvalid;
    logic                          tready;
    logic [C_AXIS_TDATA_WIDTH-1:0] tdata;
    logic                          tlast;
    logic                          tuser;

    modport master (output tvalid, output tdata, output tlast, output tuser, input tready);
    modport slave  (input tvalid, input tdata, input tlast, input tuser, output tready);

endinterface

// File: rtl/axis_pkt_arbiter_rr_pick2.sv
// Combinational two-way round-robin picker.
// When both sources request, the source that did not win last time is picked; the output is one-hot, or zero if there is no request.
module axis_rr_pick2
    import axis_pkt_arbiter_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last_grant,
    output logic [1:0] pick
);

    always_comb begin
        pick = '0;
        case (req)
            2'b01:   pick = 2'b01;
            2'b10:   pick = 2'b10;
            2'b11:   pick = src_onehot((last_grant == SRC0) ? SRC1 : SRC0);
            default: pick = '0;
        endcase
    end

endmodule

// File: rtl/axis_pkt_arbiter.sv
// Packet-granular 2:1 AXI-Stream arbiter with round-robin grant, locked from the first beat through tlast.
// The granted source is muxed straight through to the output, and a counter per source tracks completed packets.
module axis_pkt_arbiter
    import axis_pkt_arbiter_pkg::*;
#(
    parameter int unsigned C_AXIS_TDATA_WIDTH = 32,
    parameter int unsigned C_CNT_WIDTH        = 16
) (
    input  logic                   aclk,
    input  logic                   areset,
    axis_pkt_arbiter_if.slave      s0_axis,
    axis_pkt_arbiter_if.slave      s1_axis,
    axis_pkt_arbiter_if.master     m_axis,
    input  logic [1:0]             src_en,
    output logic [1:0]             grant,
    output logic                   busy,
    output logic [C_CNT_WIDTH-1:0] pkt_cnt0,
    output logic [C_CNT_WIDTH-1:0] pkt_cnt1
);

    localparam logic [C_CNT_WIDTH-1:0] CNT_ONE = {{(C_CNT_WIDTH-1){1'b0}}, 1'b1};

    logic [0:0]             state_q, state_d;
    logic [1:0]             grant_q, grant_d;
    logic                   last_grant_q, last_grant_d;
    logic [C_CNT_WIDTH-1:0] pkt_cnt0_q, pkt_cnt0_d;
    logic [C_CNT_WIDTH-1:0] pkt_cnt1_q, pkt_cnt1_d;

    logic [1:0]                    req;
    logic [1:0]                    pick;
    logic                          owner;
    logic                          xfer;
    logic                          mux_tvalid;
    logic [C_AXIS_TDATA_WIDTH-1:0] mux_tdata;
    logic                          mux_tlast;
    logic                          mux_tuser;
    logic                          s0_rdy;
    logic                          s1_rdy;

    assign req   = {s1_axis.tvalid & src_en[1], s0_axis.tvalid & src_en[0]};
    assign owner = grant_q[1] ? SRC1 : SRC0;

    axis_rr_pick2 u_pick (
        .req        (req),
        .last_grant (last_grant_q),
        .pick       (pick)
    );

    // Data path: in IDLE everything is driven low, so no beat can be offered or accepted.
    always_comb begin
        mux_tvalid = 1'b0;
        mux_tdata  = '0;
        mux_tlast  = 1'b0;
        mux_tuser  = 1'b0;
        s0_rdy     = 1'b0;
        s1_rdy     = 1'b0;
        if (state_q == ST_BUSY) begin
            if (owner == SRC1) begin
                mux_tvalid = s1_axis.tvalid;
                mux_tdata  = s1_axis.tdata;
                mux_tlast  = s1_axis.tlast;
                mux_tuser  = s1_axis.tuser;
                s1_rdy     = m_axis.tready;
            end else begin
                mux_tvalid = s0_axis.tvalid;
                mux_tdata  = s0_axis.tdata;
                mux_tlast  = s0_axis.tlast;
                mux_tuser  = s0_axis.tuser;
                s0_rdy     = m_axis.tready;
            end
        end
    end

    assign xfer = mux_tvalid & m_axis.tready;

    // Grant can change only in IDLE or on an accepted tlast beat, so an offered beat stays stable until it is accepted.
    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        pkt_cnt0_d   = pkt_cnt0_q;
        pkt_cnt1_d   = pkt_cnt1_q;
        if (state_q == ST_IDLE) begin
            if (|pick) begin
                grant_d = pick;
                state_d = ST_BUSY;
            end
        end else if (xfer && mux_tlast) begin
            if (owner == SRC1) begin
                pkt_cnt1_d = pkt_cnt1_q + CNT_ONE;
            end else begin
                pkt_cnt0_d = pkt_cnt0_q + CNT_ONE;
            end
            last_grant_d = owner;
            grant_d      = '0;
            state_d      = ST_IDLE;
        end
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            state_q      <= ST_IDLE;
            grant_q      <= '0;
            last_grant_q <= SRC1;
            pkt_cnt0_q   <= '0;
            pkt_cnt1_q   <= '0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            pkt_cnt0_q   <= pkt_cnt0_d;
            pkt_cnt1_q   <= pkt_cnt1_d;
        end
    end

    assign m_axis.tvalid  = mux_tvalid;
    assign m_axis.tdata   = mux_tdata;
    assign m_axis.tlast   = mux_tlast;
    assign m_axis.tuser   = mux_tuser;
    assign s0_axis.tready = s0_rdy;
    assign s1_axis.tready = s1_rdy;

    assign grant    = grant_q;
    assign busy     = (state_q == ST_BUSY);
    assign pkt_cnt0 = pkt_cnt0_q;
    assign pkt_cnt1 = pkt_cnt1_q;

endmodule

// File: tb/tb_axis_pkt_arbiter.sv
// Directed-vector bench for axis_pkt_arbiter: each record gives the inputs for one cycle and the outputs expected in that cycle.
// A table covers the basic flows, and short hand-built sequences cover the multi-cycle corner cases.
module tb_axis_pkt_arbiter;

    localparam int unsigned DW = 32;
    localparam int unsigned CW = 16;

    logic          aclk = 1'b0;
    logic          areset;
    logic [1:0]    src_en;
    logic [1:0]    grant;
    logic          busy;
    logic [CW-1:0] pkt_cnt0;
    logic [CW-1:0] pkt_cnt1;

    axis_pkt_arbiter_if #(.C_AXIS_TDATA_WIDTH(DW)) s0_if ();
    axis_pkt_arbiter_if #(.C_AXIS_TDATA_WIDTH(DW)) s1_if ();
    axis_pkt_arbiter_if #(.C_AXIS_TDATA_WIDTH(DW)) m_if ();

    axis_pkt_arbiter #(
        .C_AXIS_TDATA_WIDTH (DW),
        .C_CNT_WIDTH        (CW)
    ) dut (
        .aclk     (aclk),
        .areset   (areset),
        .s0_axis  (s0_if),
        .s1_axis  (s1_if),
        .m_axis   (m_if),
        .src_en   (src_en),
        .grant    (grant),
        .busy     (busy),
        .pkt_cnt0 (pkt_cnt0),
        .pkt_cnt1 (pkt_cnt1)
    );

    always #5 aclk = ~aclk;

    typedef struct packed {
        logic          rst;
        logic [1:0]    en;
        logic          v0;
        logic [DW-1:0] d0;
        logic          l0;
        logic          u0;
        logic          v1;
        logic [DW-1:0] d1;
        logic          l1;
        logic          u1;
        logic          mr;
        logic          ev;
        logic [DW-1:0] ed;
        logic          el;
        logic          eu;
        logic [1:0]    erdy;
        logic [1:0]    eg;
        logic          eb;
        logic [CW-1:0] ec0;
        logic [CW-1:0] ec1;
    } vec_t;

    int unsigned nvec = 0;
    int unsigned nerr = 0;

    // The arbiter is idle: nothing is offered downstream and no source is ready.
    function automatic vec_t idle_v(input logic [1:0] en, input logic [CW-1:0] c0, input logic [CW-1:0] c1);
        vec_t v;
        v     = '0;
        v.en  = en;
        v.mr  = 1'b1;
        v.ec0 = c0;
        v.ec1 = c1;
        return v;
    endfunction

    // Source src owns the output and offers one beat.
    function automatic vec_t beat_v(input logic [1:0] en, input logic src, input logic [DW-1:0] data,
                                    input logic last, input logic user, input logic mr,
                                    input logic [CW-1:0] c0, input logic [CW-1:0] c1);
        vec_t v;
        v     = '0;
        v.en  = en;
        v.mr  = mr;
        if (src) begin
            v.v1 = 1'b1; v.d1 = data; v.l1 = last; v.u1 = user;
        end else begin
            v.v0 = 1'b1; v.d0 = data; v.l0 = last; v.u0 = user;
        end
        v.ev   = 1'b1;
        v.ed   = data;
        v.el   = last;
        v.eu   = user;
        v.erdy = mr ? (src ? 2'b10 : 2'b01) : 2'b00;
        v.eg   = src ? 2'b10 : 2'b01;
        v.eb   = 1'b1;
        v.ec0  = c0;
        v.ec1  = c1;
        return v;
    endfunction

    task automatic apply(input vec_t v, input string name, input bit chk);
        areset       = v.rst;
        src_en       = v.en;
        s0_if.tvalid = v.v0; s0_if.tdata = v.d0; s0_if.tlast = v.l0; s0_if.tuser = v.u0;
        s1_if.tvalid = v.v1; s1_if.tdata = v.d1; s1_if.tlast = v.l1; s1_if.tuser = v.u1;
        m_if.tready  = v.mr;
        @(negedge aclk);
        if (chk) begin
            nvec++;
            if ({m_if.tvalid, m_if.tdata, m_if.tlast, m_if.tuser, s1_if.tready, s0_if.tready, grant, busy, pkt_cnt0, pkt_cnt1}
                !== {v.ev, v.ed, v.el, v.eu, v.erdy, v.eg, v.eb, v.ec0, v.ec1}) begin
                nerr++;
                $display("FAIL %s @%0t: got v=%b d=%h l=%b u=%b rdy=%b g=%b busy=%b c0=%0d c1=%0d, want v=%b d=%h l=%b u=%b rdy=%b g=%b busy=%b c0=%0d c1=%0d",
                         name, $time, m_if.tvalid, m_if.tdata, m_if.tlast, m_if.tuser, {s1_if.tready, s0_if.tready},
                         grant, busy, pkt_cnt0, pkt_cnt1, v.ev, v.ed, v.el, v.eu, v.erdy, v.eg, v.eb, v.ec0, v.ec1);
            end
        end
        @(posedge aclk);
        #1;
    endtask

    vec_t          tbl [15];
    vec_t          v;
    logic          bp_mr   [7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    logic [DW-1:0] bp_dat  [7] = '{32'h30, 32'h31, 32'h31, 32'h31, 32'h32, 32'h32, 32'h32};
    logic          bp_last [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    logic [CW-1:0] e0, e1;
    logic [DW-1:0] k0, k1;
    logic          own;

    initial begin
        // Table part 1: a single-source 4-beat packet. s1 is valid but disabled, so it must never be granted.
        tbl[0]  = idle_v(2'b00, 16'd0, 16'd0);
        tbl[1]  = idle_v(2'b01, 16'd0, 16'd0);
        tbl[1].v0 = 1'b1; tbl[1].d0 = 32'hA0; tbl[1].u0 = 1'b1; tbl[1].v1 = 1'b1; tbl[1].d1 = 32'hBB;
        tbl[2]  = beat_v(2'b01, 1'b0, 32'hA0, 1'b0, 1'b1, 1'b1, 16'd0, 16'd0);
        tbl[3]  = beat_v(2'b01, 1'b0, 32'hA1, 1'b0, 1'b0, 1'b1, 16'd0, 16'd0);
        tbl[4]  = beat_v(2'b01, 1'b0, 32'hA2, 1'b0, 1'b0, 1'b1, 16'd0, 16'd0);
        tbl[5]  = beat_v(2'b01, 1'b0, 32'hA3, 1'b1, 1'b0, 1'b1, 16'd0, 16'd0);
        for (int unsigned i = 2; i < 6; i++) begin
            tbl[i].v1 = 1'b1; tbl[i].d1 = 32'hBB;
        end
        tbl[6]  = idle_v(2'b01, 16'd1, 16'd0);
        tbl[6].v1 = 1'b1; tbl[6].d1 = 32'hBB;
        tbl[7]  = idle_v(2'b00, 16'd1, 16'd0);
        tbl[7].rst = 1'b1;
        // Table part 2: a tie after reset. Source 0 goes first, then one bubble, then source 1.
        tbl[8]  = idle_v(2'b11, 16'd0, 16'd0);
        tbl[8].v0 = 1'b1; tbl[8].d0 = 32'h10; tbl[8].u0 = 1'b1;
        tbl[9]  = beat_v(2'b11, 1'b0, 32'h10, 1'b0, 1'b1, 1'b1, 16'd0, 16'd0);
        tbl[10] = beat_v(2'b11, 1'b0, 32'h11, 1'b1, 1'b0, 1'b1, 16'd0, 16'd0);
        tbl[11] = idle_v(2'b11, 16'd1, 16'd0);
        for (int unsigned i = 8; i < 12; i++) begin
            tbl[i].v1 = 1'b1; tbl[i].d1 = 32'h20; tbl[i].u1 = 1'b1;
        end
        tbl[12] = beat_v(2'b11, 1'b1, 32'h20, 1'b0, 1'b1, 1'b1, 16'd1, 16'd0);
        tbl[13] = beat_v(2'b11, 1'b1, 32'h21, 1'b1, 1'b0, 1'b1, 16'd1, 16'd0);
        tbl[14] = idle_v(2'b11, 16'd1, 16'd1);

        areset = 1'b1;
        src_en = 2'b00;
        s0_if.tvalid = 1'b0; s0_if.tdata = '0; s0_if.tlast = 1'b0; s0_if.tuser = 1'b0;
        s1_if.tvalid = 1'b0; s1_if.tdata = '0; s1_if.tlast = 1'b0; s1_if.tuser = 1'b0;
        m_if.tready  = 1'b0;
        repeat (2) @(posedge aclk);
        #1;

        for (int unsigned i = 0; i < 15; i++) begin
            apply(tbl[i], $sformatf("tbl%0d", i), 1'b1);
        end

        // Backpressure on a 3-beat s1 packet: each beat is held until it is accepted.
        v = idle_v(2'b10, 16'd1, 16'd1);
        v.v1 = 1'b1; v.d1 = 32'h30; v.u1 = 1'b1;
        apply(v, "bp_arb", 1'b1);
        for (int unsigned i = 0; i < 7; i++) begin
            apply(beat_v(2'b10, 1'b1, bp_dat[i], bp_last[i], (i == 0), bp_mr[i], 16'd1, 16'd1),
                  $sformatf("bp%0d", i), 1'b1);
        end
        apply(idle_v(2'b10, 16'd1, 16'd2), "bp_done", 1'b1);

        // Fairness: both sources keep offering 1-beat packets, so the grant must alternate strictly.
        v = idle_v(2'b11, 16'd1, 16'd2);
        v.rst = 1'b1;
        apply(v, "fair_rst", 1'b1);
        e0 = '0; e1 = '0; k0 = '0; k1 = '0;
        for (int unsigned i = 0; i < 20; i++) begin
            own = i[0];
            v = idle_v(2'b11, e0, e1);
            v.v0 = 1'b1; v.d0 = 32'h100 + k0; v.l0 = 1'b1;
            v.v1 = 1'b1; v.d1 = 32'h200 + k1; v.l1 = 1'b1;
            apply(v, $sformatf("fair_idle%0d", i), 1'b1);
            v = beat_v(2'b11, own, own ? (32'h200 + k1) : (32'h100 + k0), 1'b1, 1'b0, 1'b1, e0, e1);
            v.v0 = 1'b1; v.d0 = 32'h100 + k0; v.l0 = 1'b1;
            v.v1 = 1'b1; v.d1 = 32'h200 + k1; v.l1 = 1'b1;
            apply(v, $sformatf("fair_beat%0d", i), 1'b1);
            if (own) begin
                k1 = k1 + 32'd1; e1 = e1 + 16'd1;
            end else begin
                k0 = k0 + 32'd1; e0 = e0 + 16'd1;
            end
        end
        apply(idle_v(2'b00, 16'd10, 16'd10), "fair_cnt", 1'b1);

        // src_en[0] drops after the first beat of a 4-beat s0 packet: the packet completes, then only s1 is served.
        v = idle_v(2'b11, e0, e1);
        v.v0 = 1'b1; v.d0 = 32'h50; v.v1 = 1'b1; v.d1 = 32'h60; v.l1 = 1'b1;
        apply(v, "en_arb", 1'b1);
        for (int unsigned b = 0; b < 4; b++) begin
            v = beat_v((b == 0) ? 2'b11 : 2'b10, 1'b0, 32'h50 + b, (b == 3), 1'b0, 1'b1, e0, e1);
            v.v1 = 1'b1; v.d1 = 32'h60; v.l1 = 1'b1;
            apply(v, $sformatf("en_beat%0d", b), 1'b1);
        end
        e0 = e0 + 16'd1;
        for (int unsigned r = 0; r < 3; r++) begin
            v = idle_v(2'b10, e0, e1);
            v.v0 = 1'b1; v.d0 = 32'h54; v.v1 = 1'b1; v.d1 = 32'h60 + r; v.l1 = 1'b1;
            apply(v, $sformatf("en_idle%0d", r), 1'b1);
            v = beat_v(2'b10, 1'b1, 32'h60 + r, 1'b1, 1'b0, 1'b1, e0, e1);
            v.v0 = 1'b1; v.d0 = 32'h54;
            apply(v, $sformatf("en_s1_%0d", r), 1'b1);
            e1 = e1 + 16'd1;
        end

        // Reset after beat 2 of an s0 packet: the grant is dropped at once and the counters clear.
        v = idle_v(2'b01, e0, e1);
        v.v0 = 1'b1; v.d0 = 32'h70;
        apply(v, "rst_arb", 1'b1);
        apply(beat_v(2'b01, 1'b0, 32'h70, 1'b0, 1'b0, 1'b1, e0, e1), "rst_b0", 1'b1);
        apply(beat_v(2'b01, 1'b0, 32'h71, 1'b0, 1'b0, 1'b1, e0, e1), "rst_b1", 1'b1);
        v = beat_v(2'b01, 1'b0, 32'h72, 1'b0, 1'b0, 1'b1, e0, e1);
        v.rst = 1'b1;
        apply(v, "rst_pulse", 1'b0);
        v = idle_v(2'b01, 16'd0, 16'd0);
        v.v0 = 1'b1; v.d0 = 32'h80; v.l0 = 1'b1;
        apply(v, "rst_after", 1'b1);
        apply(beat_v(2'b01, 1'b0, 32'h80, 1'b1, 1'b0, 1'b1, 16'd0, 16'd0), "rst_regrant", 1'b1);
        apply(idle_v(2'b01, 16'd1, 16'd0), "rst_cnt", 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
